// File: rtl/mulf_seq.sv
// mulf_seq: multi-cycle IEEE-754 single-precision multiplier (shift-add, truncating)
module mulf_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [EXP_W+MANT_W:0]     a,
  input  logic [EXP_W+MANT_W:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [EXP_W+MANT_W:0]     s,
  output logic                      ze,
  output logic                      ov,
  output logic                      uf
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int W    = EXP_W + MANT_W + 1;
  localparam int MW   = MANT_W + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(MW);
  localparam logic [CW-1:0] LAST = CW'(MW - 1);
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t st, nxt;
  logic              sign, zflag;
  logic [MW-1:0]     ma, mb;
  logic [PW-1:0]     p;
  logic [EW-1:0]     esum, e;
  logic [CW-1:0]     cnt;
  logic [MANT_W-1:0] mant;
  logic              e_ov, e_uf;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  // next-state: one pass of MUL per mantissa bit, then normalize and report
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? MUL : IDLE;
      MUL:     nxt = (cnt == LAST) ? NORM : MUL;
      NORM:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  assign busy = st != IDLE;
  assign done = st == DONE;
  // product lies in [2^46, 2^48); the top bit selects the normalize shift
  assign e    = esum + EW'(p[PW-1]);
  assign mant = p[PW-1] ? p[PW-2 -: MANT_W] : p[PW-3 -: MANT_W];
  assign e_ov = !e[EW-1] && e >= EW'(2**EXP_W - 1);
  assign e_uf = e[EW-1] || e == '0;
  // operand capture, shift-add iterations and result/flag update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign <= 1'b0; zflag <= 1'b0; ma <= '0; mb <= '0; p <= '0; esum <= '0; cnt <= '0;
      s <= '0; ze <= 1'b0; ov <= 1'b0; uf <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          sign  <= a[W-1] ^ b[W-1];
          ma    <= {1'b1, a[MANT_W-1:0]};
          mb    <= {1'b1, b[MANT_W-1:0]};
          esum  <= EW'(a[W-2:MANT_W]) + EW'(b[W-2:MANT_W]) - EW'(BIAS);
          zflag <= ~|a[W-2:0] | ~|b[W-2:0];
          p     <= '0;
          cnt   <= '0;
        end
        MUL: begin
          if (mb[0]) p <= p + (PW'(ma) << cnt);
          mb  <= mb >> 1;
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          ze <= zflag;
          ov <= !zflag && e_ov;
          uf <= !zflag && !e_ov && e_uf;
          s  <= zflag ? {sign, {(W-1){1'b0}}} :
                e_ov  ? {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}} :
                e_uf  ? {sign, {(W-1){1'b0}}} :
                        {sign, e[EXP_W-1:0], mant};
        end
        default: ;
      endcase
    end
endmodule
